// File: rtl/p4_hdr_pkg.sv
// Shared definitions for the P4 header register-block write sequencer:
// register offsets, FSM states and error codes.
package p4_hdr_pkg;

  localparam int NUM_REGS = 9;

  localparam logic [7:0] OFF_SMAC_LO = 8'h00;
  localparam logic [7:0] OFF_SMAC_HI = 8'h04;
  localparam logic [7:0] OFF_DMAC_LO = 8'h08;
  localparam logic [7:0] OFF_DMAC_HI = 8'h0C;
  localparam logic [7:0] OFF_SIP     = 8'h10;
  localparam logic [7:0] OFF_DIP     = 8'h14;
  localparam logic [7:0] OFF_SPORT   = 8'h18;
  localparam logic [7:0] OFF_DPORT   = 8'h1C;
  localparam logic [7:0] OFF_IPSUM   = 8'h20;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_BRESP = 2'd1;
  localparam logic [1:0] ERR_TMO   = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    CSUM,
    WR,
    RESP,
    DONE
  } state_t;

  function automatic logic [7:0] reg_off(input logic [3:0] idx);
    logic [7:0] off;
    off = OFF_SMAC_LO;
    case (idx)
      4'd0:    off = OFF_SMAC_LO;
      4'd1:    off = OFF_SMAC_HI;
      4'd2:    off = OFF_DMAC_LO;
      4'd3:    off = OFF_DMAC_HI;
      4'd4:    off = OFF_SIP;
      4'd5:    off = OFF_DIP;
      4'd6:    off = OFF_SPORT;
      4'd7:    off = OFF_DPORT;
      4'd8:    off = OFF_IPSUM;
      default: off = OFF_SMAC_LO;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/p4_hdr_csum.sv
// Folds a 19-bit one's-complement partial sum to 16 bits and inverts it,
// yielding the IPv4 header checksum field value.
module p4_hdr_csum
  import p4_hdr_pkg::*;
(
  input  logic [18:0] i_sum,
  output logic [15:0] o_csum
);

  logic [16:0] w_fold1;
  logic [16:0] w_fold2;

  // Two folds suffice: the first leaves at most a single carry bit.
  assign w_fold1 = {1'b0, i_sum[15:0]} + {14'h0, i_sum[18:16]};
  assign w_fold2 = {1'b0, w_fold1[15:0]} + {16'h0, w_fold1[16]};
  assign o_csum  = ~w_fold2[15:0];

endmodule

// File: rtl/p4_hdr_cfg_seq.sv
// AXI-Lite master that programs the 9 P4 header registers per request.
// Define P4_HDR_CSUM_EN to compute the IPv4 checksum before the last write.
module p4_hdr_cfg_seq
  import p4_hdr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        axil_aclk,
  input  logic        axil_areset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [47:0] cfg_smac,
  input  logic [47:0] cfg_dmac,
  input  logic [31:0] cfg_sip,
  input  logic [31:0] cfg_dip,
  input  logic [15:0] cfg_sport,
  input  logic [15:0] cfg_dport,
  input  logic [15:0] cfg_ipsum,
  output logic        m_axil_awvalid,
  output logic [31:0] m_axil_awaddr,
  input  logic        m_axil_awready,
  output logic        m_axil_wvalid,
  output logic [31:0] m_axil_wdata,
  output logic [3:0]  m_axil_wstrb,
  input  logic        m_axil_wready,
  input  logic        m_axil_bvalid,
  input  logic [1:0]  m_axil_bresp,
  output logic        m_axil_bready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  err_idx,
  output logic [1:0]  err_code
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);
`ifdef P4_HDR_CSUM_EN
  localparam state_t FIRST = CSUM;
`else
  localparam state_t FIRST = WR;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_idx;
  logic [TW-1:0] r_tmo;
  logic        r_aw_ok;
  logic        r_w_ok;
  logic [47:0] r_smac;
  logic [47:0] r_dmac;
  logic [31:0] r_sip;
  logic [31:0] r_dip;
  logic [15:0] r_sport;
  logic [15:0] r_dport;
  logic [15:0] r_ipsum;
  logic        r_err;
  logic [3:0]  r_err_idx;
  logic [1:0]  r_err_code;

  logic        w_accept;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_aw_all;
  logic        w_w_all;
  logic        w_tmo_hit;
  logic        w_set_berr;
  logic        w_set_tmo;
  logic [31:0] w_wdata;

`ifdef P4_HDR_CSUM_EN
  logic [18:0] w_sum;
  logic [15:0] w_csum;

  assign w_sum = 19'(r_ipsum)
               + 19'(r_sip[31:16]) + 19'(r_sip[15:0])
               + 19'(r_dip[31:16]) + 19'(r_dip[15:0]);

  p4_hdr_csum u_csum (
    .i_sum  (w_sum),
    .o_csum (w_csum)
  );
`endif

  assign cfg_ready = (r_state == IDLE) && !axil_areset;
  assign w_accept  = cfg_valid && cfg_ready;

  assign m_axil_awvalid = (r_state == WR) && !r_aw_ok;
  assign m_axil_wvalid  = (r_state == WR) && !r_w_ok;
  assign m_axil_bready  = (r_state == RESP);
  assign m_axil_awaddr  = BASE_ADDR + {24'h0, reg_off(r_idx)};
  assign m_axil_wdata   = w_wdata;
  assign m_axil_wstrb   = 4'hF;

  assign w_aw_hs  = m_axil_awvalid && m_axil_awready;
  assign w_w_hs   = m_axil_wvalid && m_axil_wready;
  assign w_aw_all = r_aw_ok || w_aw_hs;
  assign w_w_all  = r_w_ok || w_w_hs;
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

  assign busy     = (r_state == CSUM) || (r_state == WR)
                 || (r_state == RESP);
  assign done     = (r_state == DONE);
  assign err      = r_err;
  assign err_idx  = r_err_idx;
  assign err_code = r_err_code;

  always_comb begin
    w_wdata = 32'h0;
    case (r_idx)
      4'd0:    w_wdata = r_smac[31:0];
      4'd1:    w_wdata = {16'h0, r_smac[47:32]};
      4'd2:    w_wdata = r_dmac[31:0];
      4'd3:    w_wdata = {16'h0, r_dmac[47:32]};
      4'd4:    w_wdata = r_sip;
      4'd5:    w_wdata = r_dip;
      4'd6:    w_wdata = {16'h0, r_sport};
      4'd7:    w_wdata = {16'h0, r_dport};
      4'd8:    w_wdata = {16'h0, r_ipsum};
      default: w_wdata = 32'h0;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_set_berr = 1'b0;
    w_set_tmo  = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next = FIRST;
      CSUM: w_next = WR;
      WR: begin
        if (w_aw_all && w_w_all) begin
          w_next = RESP;
        end else if (w_tmo_hit) begin
          w_next    = DONE;
          w_set_tmo = 1'b1;
        end
      end
      RESP: begin
        if (m_axil_bvalid) begin
          if (m_axil_bresp != 2'b00) begin
            w_next     = DONE;
            w_set_berr = 1'b1;
          end else if (r_idx == LAST_IDX) begin
            w_next = DONE;
          end else begin
            w_next = WR;
          end
        end else if (w_tmo_hit) begin
          w_next    = DONE;
          w_set_tmo = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge axil_aclk or posedge axil_areset) begin
    if (axil_areset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge axil_aclk or posedge axil_areset) begin
    if (axil_areset) begin
      r_idx      <= 4'd0;
      r_tmo      <= '0;
      r_aw_ok    <= 1'b0;
      r_w_ok     <= 1'b0;
      r_smac     <= 48'h0;
      r_dmac     <= 48'h0;
      r_sip      <= 32'h0;
      r_dip      <= 32'h0;
      r_sport    <= 16'h0;
      r_dport    <= 16'h0;
      r_ipsum    <= 16'h0;
      r_err      <= 1'b0;
      r_err_idx  <= 4'd0;
      r_err_code <= ERR_NONE;
    end else begin
      // Count only while waiting on the slave; any state change reloads.
      if ((w_next != r_state) ||
          !((r_state == WR) || (r_state == RESP))) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + TW'(1);
      end
      if ((r_state == WR) && (w_next == WR)) begin
        r_aw_ok <= w_aw_all;
        r_w_ok  <= w_w_all;
      end else begin
        r_aw_ok <= 1'b0;
        r_w_ok  <= 1'b0;
      end
      if (w_accept) begin
        r_idx      <= 4'd0;
        r_smac     <= cfg_smac;
        r_dmac     <= cfg_dmac;
        r_sip      <= cfg_sip;
        r_dip      <= cfg_dip;
        r_sport    <= cfg_sport;
        r_dport    <= cfg_dport;
        r_ipsum    <= cfg_ipsum;
        r_err      <= 1'b0;
        r_err_idx  <= 4'd0;
        r_err_code <= ERR_NONE;
      end
`ifdef P4_HDR_CSUM_EN
      if (r_state == CSUM) r_ipsum <= w_csum;
`endif
      if ((r_state == RESP) && (w_next == WR)) begin
        r_idx <= r_idx + 4'd1;
      end
      if (w_set_berr) begin
        r_err      <= 1'b1;
        r_err_idx  <= r_idx;
        r_err_code <= ERR_BRESP;
      end
      if (w_set_tmo) begin
        r_err      <= 1'b1;
        r_err_idx  <= r_idx;
        r_err_code <= ERR_TMO;
      end
    end
  end

endmodule

// File: tb/tb_p4_hdr_cfg_seq.sv
// Scoreboard bench for p4_hdr_cfg_seq: a behavioural AXI-Lite slave with
// tunable latencies, a request model, and a decoupled write/done monitor.
module tb_p4_hdr_cfg_seq;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int TMO = 16;
`ifdef P4_HDR_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [47:0] cfg_smac = '0;
  logic [47:0] cfg_dmac = '0;
  logic [31:0] cfg_sip = '0;
  logic [31:0] cfg_dip = '0;
  logic [15:0] cfg_sport = '0;
  logic [15:0] cfg_dport = '0;
  logic [15:0] cfg_ipsum = '0;
  logic        awvalid;
  logic [31:0] awaddr;
  logic        awready;
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  err_idx;
  logic [1:0]  err_code;

  p4_hdr_cfg_seq #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .axil_aclk      (clk),
    .axil_areset    (rst),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_smac       (cfg_smac),
    .cfg_dmac       (cfg_dmac),
    .cfg_sip        (cfg_sip),
    .cfg_dip        (cfg_dip),
    .cfg_sport      (cfg_sport),
    .cfg_dport      (cfg_dport),
    .cfg_ipsum      (cfg_ipsum),
    .m_axil_awvalid (awvalid),
    .m_axil_awaddr  (awaddr),
    .m_axil_awready (awready),
    .m_axil_wvalid  (wvalid),
    .m_axil_wdata   (wdata),
    .m_axil_wstrb   (wstrb),
    .m_axil_wready  (wready),
    .m_axil_bvalid  (bvalid),
    .m_axil_bresp   (bresp),
    .m_axil_bready  (bready),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .err_idx        (err_idx),
    .err_code       (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int err;
    int idx;
    int code;
    int lat;
  } dn_t;

  wr_t  exp_wr[$];
  dn_t  exp_dn[$];
  logic [31:0] mq_a[$];
  logic [31:0] mq_d[$];
  int acc_cyc = 0;
  int done_cnt = 0;

  // Slave knobs
  int aw_lat = 0;
  int w_lat = 0;
  int b_lat = 0;
  int err_at = -1;
  logic [1:0] err_resp = 2'b10;

  // ---------------- behavioural AXI-Lite slave ----------------
  initial begin
    int aw_cnt, w_cnt, b_cnt, cur_idx;
    bit aw_got, w_got, s_aw, s_w, s_b;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; cur_idx = 0;
    aw_got = 0; w_got = 0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    forever begin
      @(negedge clk);
      s_aw = awvalid && awready;
      s_w  = wvalid && wready;
      s_b  = bvalid && bready;
      if (awvalid && !s_aw) aw_cnt++;
      if (wvalid && !s_w) w_cnt++;
      if (s_aw) begin
        aw_cnt = 0; aw_got = 1;
        cur_idx = int'((awaddr - BASE) >> 2);
      end
      if (s_w) begin
        w_cnt = 0; w_got = 1;
      end
      @(posedge clk);
      #1;
      if (rst) begin
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_got = 0; w_got = 0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      end else begin
        awready = (aw_cnt >= aw_lat);
        wready  = (w_cnt >= w_lat);
        if (s_b) begin
          bvalid = 1'b0; bresp = 2'b00;
          aw_got = 0; w_got = 0; b_cnt = 0;
        end else if (aw_got && w_got && !bvalid) begin
          if (b_cnt >= b_lat) begin
            bvalid = 1'b1;
            bresp = (cur_idx == err_at) ? err_resp : 2'b00;
          end else begin
            b_cnt++;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit aw_stall, w_stall;
    logic [31:0] p_a, p_d;
    aw_stall = 0; w_stall = 0; p_a = '0; p_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mq_a.delete();
        mq_d.delete();
        aw_stall = 0; w_stall = 0;
      end else begin
        if (aw_stall && awvalid) chk("awaddr_stable", awaddr, p_a);
        if (w_stall && wvalid) chk("wdata_stable", wdata, p_d);
        aw_stall = awvalid && !awready;
        w_stall  = wvalid && !wready;
        p_a = awaddr;
        p_d = wdata;
        if (awvalid && awready) mq_a.push_back(awaddr);
        if (wvalid && wready) begin
          mq_d.push_back(wdata);
          chk("wstrb", wstrb, 4'hF);
        end
        while (mq_a.size() > 0 && mq_d.size() > 0) begin
          logic [31:0] a, d;
          a = mq_a.pop_front();
          d = mq_d.pop_front();
          if (exp_wr.size() == 0) begin
            chk("unexpected_write_addr", a, 32'hFFFF_FFFF);
          end else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("write_addr", a, e.a);
            chk("write_data", d, e.d);
          end
        end
        if (done) begin
          done_cnt++;
          if (exp_dn.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            dn_t e;
            e = exp_dn.pop_front();
            chk("done_err", err, e.err);
            chk("done_err_idx", err_idx, e.idx);
            chk("done_err_code", err_code, e.code);
            if (e.lat >= 0) chk("done_latency", cyc - acc_cyc, e.lat);
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_csum(input logic [15:0] p,
                                           input logic [31:0] s,
                                           input logic [31:0] d);
    int unsigned t;
    logic [15:0] r;
    t = p + s[31:16] + s[15:0] + d[31:16] + d[15:0];
    while ((t >> 16) != 0) t = (t & 32'hFFFF) + (t >> 16);
    r = t[15:0];
    return ~r;
  endfunction

  function automatic logic [31:0] ref_word(input int i);
    logic [15:0] last;
    last = CS ? ref_csum(cfg_ipsum, cfg_sip, cfg_dip) : cfg_ipsum;
    case (i)
      0: return cfg_smac[31:0];
      1: return {16'h0, cfg_smac[47:32]};
      2: return cfg_dmac[31:0];
      3: return {16'h0, cfg_dmac[47:32]};
      4: return cfg_sip;
      5: return cfg_dip;
      6: return {16'h0, cfg_sport};
      7: return {16'h0, cfg_dport};
      default: return {16'h0, last};
    endcase
  endfunction

  // Drive one request; code 0=ok, 1=bresp error at e_idx, 2=timeout.
  // Pass wait_dn=0 to return right after acceptance.
  task automatic issue(input logic [47:0] sm, input logic [47:0] dm,
                       input logic [31:0] si, input logic [31:0] di,
                       input logic [15:0] sp, input logic [15:0] dp,
                       input logic [15:0] ip, input int code,
                       input int e_idx, input int lat, input bit wait_dn);
    int n, d0;
    bit got;
    @(posedge clk);
    #1;
    cfg_smac = sm; cfg_dmac = dm; cfg_sip = si; cfg_dip = di;
    cfg_sport = sp; cfg_dport = dp; cfg_ipsum = ip;
    n = (code == 0) ? 9 : (code == 1) ? e_idx + 1 : 0;
    for (int i = 0; i < n; i++) exp_wr.push_back('{BASE + 32'(4 * i), ref_word(i)});
    exp_dn.push_back('{(code != 0) ? 1 : 0, (code != 0) ? e_idx : 0, code, lat});
    d0 = done_cnt;
    cfg_valid = 1'b1;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (cfg_ready) begin
        got = 1;
        acc_cyc = cyc;
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("busy_after_accept", busy, 1);
    chk("err_cleared", err, 0);
    if (wait_dn) begin
      got = 0;
      for (int k = 0; k < 400 && !got; k++) begin
        @(negedge clk);
        if (done_cnt != d0) got = 1;
      end
      if (!got) begin
        chk("done_timeout", 0, 1);
        exp_dn.delete();
        exp_wr.delete();
      end
      repeat (3) @(negedge clk);
      chk("done_once", done_cnt - d0, 1);
      chk("exp_writes_drained", exp_wr.size(), 0);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_wr.delete();
    exp_dn.delete();
  endtask

  initial begin
    bit hit;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cfg_ready", cfg_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_err", {err, err_idx, err_code}, 0);

    // 1: zero-wait slave
    issue(48'h0A0B0C0D0E0F, 48'h112233445566, 32'h0A000001, 32'h0A000002,
          16'd1234, 16'd80, 16'h1234, 0, 0, 19 + CS, 1);
    chk("t1_err", err, 0);

    // 2: checksum vector (verbatim write when the checksum is disabled)
    issue(48'h020000000001, 48'h020000000002, 32'hC0A80001, 32'hC0A800C7,
          16'd5000, 16'd6000, 16'h4500 + 16'h0054 + 16'h4011, 0, 0, 19 + CS, 1);

    // 3: AW accepted 3 cycles ahead of W
    w_lat = 3;
    issue(48'hAABBCCDDEEFF, 48'h000102030405, 32'h01020304, 32'h05060708,
          16'hFFFF, 16'h0001, 16'hBEEF, 0, 0, -1, 1);
    w_lat = 0;

    // 4: SLVERR on idx 4
    err_at = 4;
    issue(48'h0, 48'hFFFFFFFFFFFF, 32'hDEADBEEF, 32'hCAFEF00D,
          16'h0, 16'hFFFF, 16'h0, 1, 4, -1, 1);
    repeat (4) @(negedge clk);
    chk("t4_err_sticky", {err, err_idx, err_code}, {1'b1, 4'd4, 2'd1});
    err_at = -1;

    // 5: awready stuck low -> timeout
    aw_lat = 1000;
    issue(48'h1, 48'h2, 32'h3, 32'h4, 16'h5, 16'h6, 16'h7,
          2, 0, 1 + CS + TMO, 1);
    chk("t5_valids_low", {awvalid, wvalid}, 0);
    aw_lat = 0;
    pulse_reset();

    // 6: reset during RESP of idx 3
    b_lat = 5;
    issue(48'h665544332211, 48'h0, 32'h7F000001, 32'h7F000002,
          16'd1, 16'd2, 16'd3, 0, 0, -1, 0);
    hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      if (bready && awaddr == BASE + 32'h0C) hit = 1;
    end
    chk("t6_reached_idx3_resp", hit, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_drops", {awvalid, wvalid, bready, cfg_ready, busy}, 0);
    exp_wr.delete();
    exp_dn.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    b_lat = 0;
    issue(48'h0A0B0C0D0E0F, 48'h1, 32'h2, 32'h3, 16'h4, 16'h5, 16'h6,
          0, 0, 19 + CS, 1);

    // Randomised requests and slave timing
    for (int r = 0; r < 20; r++) begin
      int e;
      aw_lat = $urandom_range(0, 3);
      w_lat  = $urandom_range(0, 3);
      b_lat  = $urandom_range(0, 3);
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
      err_at = e;
      err_resp = $urandom_range(0, 1) ? 2'b10 : 2'b11;
      issue({$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom,
            16'($urandom), 16'($urandom), 16'($urandom),
            (e >= 0) ? 1 : 0, (e >= 0) ? e : 0, -1, 1);
    end
    err_at = -1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
